registro_tablero: RTL

Sequential game-state holder for the 4x4 2048 board, sitting directly upstream and downstream of `control_movimiento`. It stores the current board and drives it plus a direction selector into `control_movimiento`. It captures the moved board and win/lose flags that `control_movimiento` returns. After every move that changes the board, it spawns a new 2 or 4 tile in a pseudo-random empty cell and counts valid moves.

---
 rtl/registro_tablero.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/registro_tablero.sv
// rtl/registro_tablero.sv - 2048 board register: move sequencing, tile spawn, win/lose tracking
module registro_tablero (
  input  logic        clk,
  input  logic        rst,
  input  logic        mov_valido,
  input  logic [2:0]  direccion,
  input  logic        reiniciar,
  input  logic        cargar,
  input  logic [31:0] matriz_carga  [4][4],
  input  logic [31:0] matriz_movida [4][4],
  input  logic [31:0] gano_in,
  input  logic [31:0] perdio_in,
  output logic [31:0] matriz_actual [4][4],
  output logic [2:0]  selector,
  output logic        ocupado,
  output logic        gano_juego,
  output logic        perdio_juego,
  output logic [15:0] movimientos
);

  typedef enum logic [2:0] {INIT, IDLE, MOVE, CHECK, SPAWN, EVAL, WIN, LOSE} estado_t;

  estado_t     estado, estado_sig;
  logic [15:0] lfsr;
  logic [31:0] temp [4][4];
  logic [1:0]  pendientes;
  logic [3:0]  idx;
  logic [3:0]  escaneos;
  logic [31:0] valor;
  logic        dir_legal, iguales, celda_libre, muestrear;

  assign dir_legal   = direccion inside {3'b001, 3'b010, 3'b011, 3'b100};
  assign celda_libre = (matriz_actual[idx[3:2]][idx[1:0]] == 32'd0);
  assign ocupado     = (estado != IDLE) && (estado != WIN) && (estado != LOSE);

  always_comb begin
    iguales = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (temp[r][c] != matriz_actual[r][c]) iguales = 1'b0;
  end

  // A fresh cell/value pair is drawn whenever SPAWN is entered anew or after a successful write
  assign muestrear = (estado_sig == SPAWN) && ((estado != SPAWN) || celda_libre);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) estado <= INIT;
    else      estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    if (reiniciar) begin
      estado_sig = INIT;
    end else begin
      case (estado)
        INIT:  estado_sig = SPAWN;
        IDLE:  if (!cargar && mov_valido && dir_legal) estado_sig = MOVE;
        MOVE:  estado_sig = CHECK;
        CHECK: estado_sig = iguales ? IDLE : SPAWN;
        SPAWN: begin
          if (celda_libre)              estado_sig = (pendientes == 2'd1) ? EVAL : SPAWN;
          else if (escaneos == 4'd15)   estado_sig = EVAL;
        end
        EVAL: begin
          if (gano_in != 32'd0)         estado_sig = WIN;
          else if (perdio_in != 32'd0)  estado_sig = LOSE;
          else                          estado_sig = IDLE;
        end
        default: estado_sig = estado;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr         <= 16'hACE1;
      selector     <= 3'b000;
      gano_juego   <= 1'b0;
      perdio_juego <= 1'b0;
      movimientos  <= 16'd0;
      pendientes   <= 2'd0;
      idx          <= 4'd0;
      escaneos     <= 4'd0;
      valor        <= 32'd0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          matriz_actual[r][c] <= 32'd0;
          temp[r][c]          <= 32'd0;
        end
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

      if (muestrear) begin
        idx      <= lfsr[3:0];
        valor    <= (lfsr[7:4] == 4'd0) ? 32'd4 : 32'd2;
        escaneos <= 4'd0;
      end else if (estado == SPAWN) begin
        idx      <= idx + 4'd1;
        escaneos <= escaneos + 4'd1;
      end

      if (reiniciar) begin
        selector     <= 3'b000;
        gano_juego   <= 1'b0;
        perdio_juego <= 1'b0;
        movimientos  <= 16'd0;
      end else begin
        case (estado)
          INIT: begin
            pendientes <= 2'd2;
            for (int r = 0; r < 4; r++)
              for (int c = 0; c < 4; c++)
                matriz_actual[r][c] <= 32'd0;
          end
          IDLE: begin
            if (cargar)                        matriz_actual <= matriz_carga;
            else if (mov_valido && dir_legal)  selector <= direccion;
          end
          MOVE: temp <= matriz_movida;
          CHECK: begin
            selector <= 3'b000;
            if (!iguales) begin
              matriz_actual <= temp;
              pendientes    <= 2'd1;
              if (movimientos != 16'hFFFF) movimientos <= movimientos + 16'd1;
            end
          end
          SPAWN: begin
            if (celda_libre) begin
              matriz_actual[idx[3:2]][idx[1:0]] <= valor;
              pendientes <= pendientes - 2'd1;
            end
          end
          EVAL: begin
            if (gano_in != 32'd0)        gano_juego   <= 1'b1;
            else if (perdio_in != 32'd0) perdio_juego <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
